hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Parametrised successor to the two-operand forwarding unit: owns its own shadow tag pipeline of in-flight destination registers instead of receiving rd/write-enable from each stage.
- Generates forward selects for NUM_SRC EX-stage operands across FWD_STAGES downstream stages.
- Also detects load-use hazards and sequences a multi-cycle-op stall FSM.
- Sits beside the ID/EX pipeline register; its outputs drive the EX operand muxes and the PC/IF-ID/ID-EX enables.

Parameters:
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per instruction
- FWD_STAGES, 2, tracked stages after EX (stage0 = MEM, stage1 = WB, ...)
- CNT_W, 4, width of multi-cycle latency field
- PERF_W, 32, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_rs  in  NUM_SRC*REG_AW  ID-stage source registers
- id_rs_used  in  NUM_SRC  ID source actually read
- ex_rs  in  NUM_SRC*REG_AW  EX-stage source registers
- ex_rs_used  in  NUM_SRC  EX source actually read
- ex_valid  in  1  EX holds a real instruction
- ex_rd  in  REG_AW  EX destination
- ex_wb_en  in  1  EX instruction writes back
- ex_is_load  in  1  EX instruction is a load
- ex_mc_start  in  1  EX instruction is multi-cycle
- ex_mc_lat  in  CNT_W  its total EX latency L (1..2^CNT_W-1)
- flush  in  1  kill IF/ID instructions (branch taken in EX)
- fwd_sel  out  NUM_SRC*SEL_W  per-operand select; SEL_W = $clog2(FWD_STAGES+1)
- stall_id  out  1  freeze PC and IF/ID
- bubble_ex  out  1  load ID/EX with a bubble next edge
- hold_ex  out  1  freeze ID/EX (multi-cycle op in EX)
- mc_busy  out  1  FSM in BUSY
- stall_cycles  out  PERF_W  count of cycles with stall_id=1

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All tag entries invalid.
  - FSM IDLE, cnt=0, stall_cycles=0.
  - Combinational outputs then evaluate to fwd_sel=0, stall_id=0, bubble_ex=0, hold_ex=0, mc_busy=0.
  - Reset mid-multi-cycle op aborts it.
- Tag entry: {valid, rd, wb_en, is_load}.
- Tag shift occurs every cycle:
  - stage k <= stage k-1 for k>=1.
  - stage0 <= {ex_valid & ~hold_ex, ex_rd, ex_wb_en, ex_is_load}.
  - A held EX therefore injects a bubble tag while older entries keep draining.
- fwd_sel[i] (combinational, zero latency):
  - Equals j+1 for the lowest j with valid & wb_en & rd==ex_rs[i] & rd!=0 & ex_rs_used[i].
  - Otherwise 0. Youngest producer wins.
  - x0 is never forwarded.
  - Encoding: 0 = register file, 1 = MEM, 2 = WB, ...
- Load-use (combinational):
  - lu = ~flush & ex_valid & ex_is_load & ex_wb_en & ex_rd!=0 & any_i(id_rs_used[i] & id_rs[i]==ex_rd).
  - lu forces stall_id=1 and bubble_ex=1 for exactly one cycle per hazard.
  - The load advances to stage0, after which forwarding from MEM resolves the dependency.
- Multi-cycle FSM:
  - IDLE:
    - ex_mc_start & ex_valid & L>=2 → hold_ex=1, stall_id=1, cnt<=L-2, next BUSY.
    - L<=1 → no stall, stay IDLE.
  - BUSY:
    - mc_busy=1; ex_mc_start is ignored.
    - cnt!=0 → hold_ex=1, stall_id=1, cnt<=cnt-1.
    - cnt==0 → hold_ex=0, stall_id=0, instruction leaves EX, next IDLE.
  - Total stall = L-1 cycles.
- Priority:
  - hold_ex and lu are mutually exclusive by construction (an mc instruction is not a load).
  - If both are asserted, hold_ex wins and bubble_ex=0.
- flush:
  - Suppresses lu only.
  - Does not affect the FSM or the tag pipeline, since the EX instruction is older than the branch target.
- stall_cycles increments when stall_id=1 and wraps at 2^PERF_W.

Decomposition:
- Package hazard_pkg holds:
  - tag_t struct {valid, rd, wb_en, is_load}
  - mc_state_e {MC_IDLE, MC_BUSY}
  - FWD_RF = 0 constant
- One natural sub-module: fwd_match. It is a per-operand priority comparator (one ex_rs vs tag array → select), instantiated NUM_SRC times by generate.

Test Plan:
- add x5 in EX, next instruction uses x5 as rs1 → fwd_sel[0]=1 next cycle; two instructions later → fwd_sel[0]=2; three later → 0.
- Producers of x7 in both MEM and WB, consumer reads x7 → fwd_sel=1 (youngest wins).
- Producer writes x0, consumer reads x0 → fwd_sel=0.
- lw x3 in EX, ID reads x3:
  - stall_id=1 and bubble_ex=1 for 1 cycle.
  - The following cycle fwd_sel=1.
  - Same stimulus with flush=1 → no stall.
- mc op with L=4 → hold_ex=stall_id=1 for 3 cycles, mc_busy=1 for cycles 2-4, then IDLE; stall_cycles +=3; meanwhile an older producer in MEM drains to WB with correct fwd_sel.
- rst_n=0 during BUSY with cnt=2 → next cycle mc_busy=0, hold_ex=0, all fwd_sel=0, stall_cycles=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / forwarding unit.
package hazard_pkg;

   // Widest register address the shadow tags can hold; REG_AW must not exceed it.
   localparam int MAX_REG_AW = 8;

   // Forward-select value meaning "take the operand from the register file".
   localparam int FWD_RF = 0;

   // One in-flight destination record per tracked stage.
   typedef struct packed {
      logic                  valid;
      logic [MAX_REG_AW-1:0] rd;
      logic                  wb_en;
      logic                  is_load;
   } tag_t;

   typedef enum logic [0:0] {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_e;

   // A tag can supply a forwarded value only if it is real and writes back.
   function automatic logic tag_can_fwd(input tag_t t);
      return t.valid & t.wb_en;
   endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_match.sv
// Priority comparator for one EX operand against all tracked stage tags.
// The youngest stage (lowest index) with a matching destination wins.
module fwd_match
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int FWD_STAGES = 2,
   parameter int SEL_W      = 2
)(
   input  logic [REG_AW-1:0]            rs_i,
   input  logic                         rs_used_i,
   input  logic [FWD_STAGES-1:0]        cand_en_i,
   input  logic [FWD_STAGES*REG_AW-1:0] cand_rd_i,
   output logic [SEL_W-1:0]             sel_o
);

   logic [SEL_W-1:0] sel_s;

   // Scan oldest to youngest so the youngest match overwrites older ones; x0 never matches.
   always_comb begin
      sel_s = SEL_W'(FWD_RF);
      for (int j = FWD_STAGES - 1; j >= 0; j--) begin
         if (rs_used_i && (rs_i != {REG_AW{1'b0}}) && cand_en_i[j] &&
             (cand_rd_i[j*REG_AW +: REG_AW] == rs_i)) begin
            sel_s = SEL_W'(j + 1);
         end else begin
            sel_s = sel_s;
         end
      end
   end

   assign sel_o = sel_s;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard / forwarding unit: shadow tag pipeline of in-flight destinations,
// per-operand forward selects, load-use detection and multi-cycle stall FSM.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int NUM_SRC    = 2,
   parameter int FWD_STAGES = 2,
   parameter int CNT_W      = 4,
   parameter int PERF_W     = 32,
   localparam int SEL_W     = $clog2(FWD_STAGES + 1)
)(
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [NUM_SRC*REG_AW-1:0]  id_rs_i,
   input  logic [NUM_SRC-1:0]         id_rs_used_i,
   input  logic [NUM_SRC*REG_AW-1:0]  ex_rs_i,
   input  logic [NUM_SRC-1:0]         ex_rs_used_i,
   input  logic                       ex_valid_i,
   input  logic [REG_AW-1:0]          ex_rd_i,
   input  logic                       ex_wb_en_i,
   input  logic                       ex_is_load_i,
   input  logic                       ex_mc_start_i,
   input  logic [CNT_W-1:0]           ex_mc_lat_i,
   input  logic                       flush_i,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
   output logic                       stall_id_o,
   output logic                       bubble_ex_o,
   output logic                       hold_ex_o,
   output logic                       mc_busy_o,
   output logic [PERF_W-1:0]          stall_cycles_o
);

   tag_t                         tag_q [FWD_STAGES];
   tag_t                         tag_d [FWD_STAGES];
   mc_state_e                    state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [PERF_W-1:0]            stall_cnt_q, stall_cnt_d;

   logic                         hold_ex_s;
   logic                         mc_busy_s;
   logic                         id_dep_s;
   logic                         lu_s;
   logic                         stall_id_s;
   logic                         bubble_ex_s;
   logic [FWD_STAGES-1:0]        cand_en_s;
   logic [FWD_STAGES*REG_AW-1:0] cand_rd_s;

   // Next tag pipeline: EX enters stage0 (as a bubble while held), older stages shift down.
   always_comb begin
      tag_d[0].valid   = ex_valid_i & ~hold_ex_s;
      tag_d[0].rd      = MAX_REG_AW'(ex_rd_i);
      tag_d[0].wb_en   = ex_wb_en_i;
      tag_d[0].is_load = ex_is_load_i;
      for (int k = 1; k < FWD_STAGES; k++) begin
         tag_d[k] = tag_q[k-1];
      end
   end

   // Tag pipeline register; it drains every cycle regardless of stalls.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int k = 0; k < FWD_STAGES; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < FWD_STAGES; k++) begin
            tag_q[k] <= tag_d[k];
         end
      end
   end

   // Flatten tags into the candidate vectors consumed by the per-operand comparators.
   always_comb begin
      cand_en_s = {FWD_STAGES{1'b0}};
      cand_rd_s = {(FWD_STAGES*REG_AW){1'b0}};
      for (int k = 0; k < FWD_STAGES; k++) begin
         cand_en_s[k]                  = tag_can_fwd(tag_q[k]);
         cand_rd_s[k*REG_AW +: REG_AW] = tag_q[k].rd[REG_AW-1:0];
      end
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_match #(
         .REG_AW     (REG_AW),
         .FWD_STAGES (FWD_STAGES),
         .SEL_W      (SEL_W)
      ) u_fwd_match (
         .rs_i      (ex_rs_i[i*REG_AW +: REG_AW]),
         .rs_used_i (ex_rs_used_i[i]),
         .cand_en_i (cand_en_s),
         .cand_rd_i (cand_rd_s),
         .sel_o     (fwd_sel_o[i*SEL_W +: SEL_W])
      );
   end

   // Does any used ID source read the EX destination?
   always_comb begin
      id_dep_s = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_rs_used_i[i] && (id_rs_i[i*REG_AW +: REG_AW] == ex_rd_i)) begin
            id_dep_s = 1'b1;
         end else begin
            id_dep_s = id_dep_s;
         end
      end
   end

   // Load-use: a branch flush kills the ID consumer, so it cannot create a hazard.
   assign lu_s = ~flush_i & ex_valid_i & ex_is_load_i & ex_wb_en_i &
                 (ex_rd_i != {REG_AW{1'b0}}) & id_dep_s;

   // Multi-cycle FSM: hold EX for L-1 cycles; cnt counts remaining held BUSY cycles.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_ex_s = 1'b0;
      mc_busy_s = 1'b0;
      case (state_q)
         MC_IDLE: begin
            if (ex_mc_start_i && ex_valid_i && (ex_mc_lat_i >= CNT_W'(2))) begin
               hold_ex_s = 1'b1;
               cnt_d     = ex_mc_lat_i - CNT_W'(2);
               state_d   = MC_BUSY;
            end else begin
               state_d   = MC_IDLE;
            end
         end
         MC_BUSY: begin
            mc_busy_s = 1'b1;
            if (cnt_q != {CNT_W{1'b0}}) begin
               hold_ex_s = 1'b1;
               cnt_d     = cnt_q - CNT_W'(1);
            end else begin
               state_d   = MC_IDLE;
            end
         end
         default: begin
            state_d = MC_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Hold has priority over load-use: no bubble while EX is frozen.
   assign stall_id_s  = hold_ex_s | lu_s;
   assign bubble_ex_s = lu_s & ~hold_ex_s;

   // Stall performance counter, free-running with natural wrap.
   always_comb begin
      if (stall_id_s) begin
         stall_cnt_d = stall_cnt_q + PERF_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // FSM state, latency counter and stall counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= MC_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         stall_cnt_q <= {PERF_W{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_id_o     = stall_id_s;
   assign bubble_ex_o    = bubble_ex_s;
   assign hold_ex_o      = hold_ex_s;
   assign mc_busy_o      = mc_busy_s;
   assign stall_cycles_o = stall_cnt_q;

endmodule
